// File: rtl/base_asplit.sv
// Chunk splitter closing the feedback loop of the base accumulator latch: carves one
// size/boundary-limited chunk per accept and returns the remaining transfer state.
module base_asplit #(
  parameter int aw  = 64,
  parameter int lw  = 32,
  parameter int tw  = 8,
  parameter int msl = 12,
  parameter int bsl = 12
) (
  input  logic                        clk,
  input  logic                        reset,
  output logic                        i_r,
  input  logic                        i_v,
  input  logic [aw+lw+tw-1:0]         i_d,
  output logic                        f_v,
  output logic [aw+lw+tw-1:0]         f_d,
  input  logic                        o_r,
  output logic                        o_v,
  output logic [aw+msl+1+tw+16+1-1:0] o_d
);

  localparam int ow = aw + msl + 1 + tw + 16 + 1;
  // Compare width wide enough for both the length and the boundary distance.
  localparam int cw = (lw > bsl + 1) ? lw : bsl + 1;

  logic [aw-1:0] in_addr;
  logic [lw-1:0] in_len;
  logic [tw-1:0] in_tag;
  logic [bsl:0]  bnd;
  logic [cw-1:0] len_w;
  logic [cw-1:0] cap_w;
  logic [cw-1:0] size_w;
  logic [msl:0]  size;
  logic          last;
  logic          accept;

  logic          o_v_q, o_v_d;
  logic [ow-1:0] o_d_q, o_d_d;
  logic [15:0]   seq_q, seq_d;

  assign {in_addr, in_len, in_tag} = i_d;

  // Bytes left before the next no-cross boundary, always in 1..2^bsl.
  assign bnd = {1'b1, {bsl{1'b0}}} - {1'b0, in_addr[bsl-1:0]};

  always_comb begin
    // NOTE: every variable written here gets a value first, so no latch is inferred.
    len_w = cw'(in_len);
    cap_w = cw'({1'b1, {msl{1'b0}}});
    if (cw'(bnd) < cap_w) cap_w = cw'(bnd);
    size_w = (len_w < cap_w) ? len_w : cap_w;
    last   = (len_w <= cap_w);
  end

  assign size   = size_w[msl:0];
  assign i_r    = ~o_v_q | o_r;
  assign accept = i_v & i_r;
  assign f_v    = i_v & ~last;
  assign f_d    = {in_addr + aw'(size), in_len - size_w[lw-1:0], in_tag};

  always_comb begin
    o_v_d = o_v_q;
    o_d_d = o_d_q;
    seq_d = seq_q;
    if (accept) begin
      o_v_d = 1'b1;
      o_d_d = {in_addr, size, in_tag, seq_q, last};
      seq_d = last ? 16'd0 : seq_q + 16'd1;
    end else if (o_r) begin
      o_v_d = 1'b0;
    end
  end

  // NOTE: the data register is reset along with valid because o_d must read 0 in reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      o_v_q <= 1'b0;
      o_d_q <= '0;
      seq_q <= '0;
    end else begin
      // NOTE: non-blocking updates so every flop samples the pre-edge values together.
      o_v_q <= o_v_d;
      o_d_q <= o_d_d;
      seq_q <= seq_d;
    end
  end

  assign o_v = o_v_q;
  assign o_d = o_d_q;

endmodule

// File: tb/tb_base_asplit.sv
// Scoreboard bench for base_asplit: a behavioural latch stage closes the feedback loop,
// and a reference splitter predicts every chunk and feedback word.
module tb_base_asplit;
  localparam int aw  = 64;
  localparam int lw  = 32;
  localparam int tw  = 8;
  localparam int msl = 12;
  localparam int bsl = 12;
  localparam int dw  = aw + lw + tw;
  localparam int ow  = aw + msl + 1 + tw + 16 + 1;

  typedef struct {
    logic [63:0] addr;
    logic [12:0] size;
    logic [7:0]  tag;
    logic [15:0] seq;
    logic        last;
    logic [63:0] naddr;
    logic [31:0] nlen;
  } chunk_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          i_r, i_v, f_v, o_r, o_v;
  logic [dw-1:0] i_d, f_d;
  logic [ow-1:0] o_d;

  logic          lt_v;
  logic [dw-1:0] lt_d;

  chunk_t        acc_q[$];
  chunk_t        out_q[$];
  logic [dw-1:0] pend[$];

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int first_ov = -1;
  int last_ov  = -1;

  base_asplit #(.aw(aw), .lw(lw), .tw(tw), .msl(msl), .bsl(bsl)) dut (
    .clk(clk), .reset(rst_n), .i_r(i_r), .i_v(i_v), .i_d(i_d),
    .f_v(f_v), .f_d(f_d), .o_r(o_r), .o_v(o_v), .o_d(o_d)
  );

  always #5 clk = ~clk;

  assign i_v = lt_v;
  assign i_d = lt_d;

  task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [ow-1:0] pack(input chunk_t c);
    return {c.addr, c.size, c.tag, c.seq, c.last};
  endfunction

  // Reference splitter: predicts every chunk of one descriptor.
  task automatic push_desc(input logic [63:0] addr, input logic [31:0] len,
                           input logic [7:0] tag, output int n);
    logic [63:0] a, l, rem, sz;
    chunk_t c;
    int s;
    a = addr; l = 64'(len); s = 0; n = 0;
    pend.push_back({addr, len, tag});
    do begin
      rem = (64'd1 << bsl) - (a % (64'd1 << bsl));
      sz  = l;
      if (sz > (64'd1 << msl)) sz = 64'd1 << msl;
      if (sz > rem) sz = rem;
      c.addr  = a;
      c.size  = sz[12:0];
      c.tag   = tag;
      c.seq   = s[15:0];
      c.last  = (sz == l);
      c.naddr = a + sz;
      c.nlen  = l[31:0] - sz[31:0];
      acc_q.push_back(c);
      out_q.push_back(c);
      a = a + sz; l = l - sz; s++; n++;
    end while (!c.last);
  endtask

  // Behavioural upstream latch: reloads from feedback, else from the descriptor queue.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lt_v <= 1'b0;
      lt_d <= '0;
    end else if (lt_v && i_r) begin
      if (f_v) lt_d <= f_d;
      else if (pend.size() != 0) lt_d <= pend.pop_front();
      else lt_v <= 1'b0;
    end else if (!lt_v && pend.size() != 0) begin
      lt_v <= 1'b1;
      lt_d <= pend.pop_front();
    end
  end

  always @(negedge clk) begin
    chunk_t e;
    if (rst_n) begin
      cyc++;
      if (o_v) begin
        if (first_ov < 0) first_ov = cyc;
        last_ov = cyc;
      end
      if (i_v && i_r) begin
        if (acc_q.size() == 0) check("spurious_accept", 128'(acc_q.size()), 128'd1);
        else begin
          e = acc_q.pop_front();
          check("f_v", 128'(f_v), 128'(!e.last));
          if (!e.last) check("f_d", 128'(f_d), 128'({e.naddr, e.nlen, e.tag}));
        end
      end
      if (o_v && o_r) begin
        if (out_q.size() == 0) check("spurious_chunk", 128'(out_q.size()), 128'd1);
        else begin
          e = out_q.pop_front();
          check("o_d", 128'(o_d), 128'(pack(e)));
        end
      end
    end
  end

  task automatic wait_drain(input string tag, input int n_exp_span);
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (out_q.size() == 0 && acc_q.size() == 0 && pend.size() == 0 && !lt_v) break;
    end
    check({tag, "_drain"}, 128'(out_q.size() + acc_q.size()), 128'd0);
    check({tag, "_span"}, 128'(last_ov - first_ov + 1), 128'(n_exp_span));
  endtask

  task automatic wait_ov(input string tag);
    int i;
    for (i = 0; i < 50; i++) begin
      @(negedge clk);
      if (o_v) break;
    end
    if (i == 50) check({tag, "_ov_timeout"}, 128'(o_v), 128'd1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    rst_n = 1'b0;
    o_r   = 1'b1;
    #12;
    check("rst_o_v", 128'(o_v), 128'd0);
    check("rst_o_d", 128'(o_d), 128'd0);
    check("rst_i_r", 128'(i_r), 128'd1);
    @(posedge clk); #1 rst_n = 1'b1;

    // Aligned split on consecutive cycles
    first_ov = -1;
    @(posedge clk); #1 push_desc(64'h1000, 32'h2800, 8'hA1, n);
    check("aligned_nchunks", 128'(n), 128'd3);
    wait_drain("aligned", n);

    // Boundary crossing
    first_ov = -1;
    @(posedge clk); #1 push_desc(64'h0FF0, 32'h40, 8'h11, n);
    wait_drain("boundary", n);

    // Zero length
    first_ov = -1;
    @(posedge clk); #1 push_desc(64'h2000, 32'h0, 8'h5A, n);
    wait_drain("zero", n);

    // Backpressure: first chunk held for three cycles
    first_ov = -1;
    @(posedge clk); #1 o_r = 1'b0;
    push_desc(64'h1000, 32'h2800, 8'h33, n);
    wait_ov("bp");
    for (int i = 0; i < 3; i++) begin
      check("bp_i_r", 128'(i_r), 128'd0);
      check("bp_hold", 128'(o_d), 128'({64'h1000, 13'h1000, 8'h33, 16'd0, 1'b0}));
      if (i < 2) @(negedge clk);
    end
    @(posedge clk); #1 o_r = 1'b1;
    wait_drain("bp", n + 3);

    // Back-to-back descriptors
    first_ov = -1;
    @(posedge clk); #1 push_desc(64'h4000, 32'h1800, 8'h01, n);
    push_desc(64'h8000, 32'h1800, 8'h02, n);
    wait_drain("b2b", 4);

    // Reset mid-descriptor
    first_ov = -1;
    @(posedge clk); #1 push_desc(64'h1000, 32'h2800, 8'hC3, n);
    wait_ov("rstmid");
    #2 rst_n = 1'b0;
    #1;
    check("rstmid_o_v", 128'(o_v), 128'd0);
    check("rstmid_o_d", 128'(o_d), 128'd0);
    check("rstmid_i_r", 128'(i_r), 128'd1);
    acc_q.delete(); out_q.delete(); pend.delete();
    @(posedge clk); #1 rst_n = 1'b1;
    first_ov = -1;
    @(posedge clk); #1 push_desc(64'h1000, 32'h2800, 8'h77, n);
    wait_drain("after_rst", n);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
